// File: rtl/jtag_scan_pkg.sv
// Shared definitions for the JTAG scan master: FSM state encoding,
// the TMS walk from Run-Test/Idle into Shift-IR/Shift-DR, and the
// default scan width.
package jtag_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TLR   = 3'd1,
        ST_PRE   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_POST  = 3'd4,
        ST_RESP  = 3'd5
    } scan_state_t;

    // Matches the debug-module jdo/sr width.
    localparam int MAX_LEN_DEFAULT = 38;

    // TMS walks, bit i is driven on the i-th TCK of the walk.
    // IR: 1,1,0,0  RTI -> Sel-DR -> Sel-IR -> Capture-IR -> Shift-IR
    // DR: 1,0,0    RTI -> Sel-DR -> Capture-DR -> Shift-DR
    localparam logic [3:0] PRE_IR_TMS = 4'b0011;
    localparam logic [5:0] PRE_IR_TCK = 6'd4;
    localparam logic [3:0] PRE_DR_TMS = 4'b0001;
    localparam logic [5:0] PRE_DR_TCK = 6'd3;

    // Exit1 -> Update (tms 1), Update -> Run-Test/Idle (tms 0).
    localparam logic [5:0] POST_TCK = 6'd2;

    function automatic logic pre_tms(input logic is_ir, input logic [1:0] idx);
        return is_ir ? PRE_IR_TMS[idx] : PRE_DR_TMS[idx];
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider for the JTAG scan master. While enabled it produces a TCK
// period of CLK_DIV low clks followed by CLK_DIV high clks, with one-clk
// strobes on the clk that starts each phase. Disabled, tck idles low and
// the divider sits at zero so the next enable starts with a fall strobe.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam logic [8:0] HALF = 9'(CLK_DIV);
    localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

    logic [8:0] div_cnt;

    assign fall_stb = en && (div_cnt == 9'd0);
    assign rise_stb = en && (div_cnt == HALF);

    // Divider counter and the registered TCK level it implies.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == LAST) ? 9'd0 : div_cnt + 9'd1;
            if (rise_stb)
                tck <= 1'b1;
            else if (fall_stb)
                tck <= 1'b0;
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: accepts one IR or DR scan command, walks the TAP from
// Run-Test/Idle into the shift state, shifts cmd_len bits LSB first while
// capturing TDO, returns to Run-Test/Idle and presents the captured bits.
// Optional feature macro: JTAG_SCAN_MASTER_TAP_RESET_EN -- after reset,
// drive TMS 1,1,1,1,1,0 to force the TAP into Run-Test/Idle before
// accepting commands. Without it the TAP is assumed to already be there.
module jtag_scan_master
    import jtag_scan_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_ir,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);

`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
    // Five ones reach Test-Logic-Reset from any TAP state, the zero lands in RTI.
    localparam logic [7:0] TLR_TMS = 8'b0001_1111;
    localparam logic [5:0] TLR_TCK = 6'd6;
`endif

    scan_state_t        state;
    logic [5:0]         bit_idx;
    logic [5:0]         len_q;
    logic               is_ir_q;
    logic [MAX_LEN-1:0] data_q;
    logic               tck_en;
    logic               fall_stb;
    logic               rise_stb;
    logic               len_bad;
    logic [5:0]         pre_last;
    logic               shift_last;

    assign tck_en     = (state == ST_TLR) || (state == ST_PRE) ||
                        (state == ST_SHIFT) || (state == ST_POST);
    assign busy       = (state != ST_IDLE);
    assign cmd_ready  = (state == ST_IDLE);
    assign len_bad    = (cmd_len == 6'd0) || (int'(cmd_len) > MAX_LEN);
    assign pre_last   = is_ir_q ? (PRE_IR_TCK - 6'd1) : (PRE_DR_TCK - 6'd1);
    assign shift_last = (bit_idx == len_q - 6'd1);

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (tck_en),
        .tck      (tck),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // Scan sequencer: TMS/TDI update on fall strobes, TDO capture and
    // bit advance on rise strobes. Walks hand over to the next walk on the
    // last rise so the following fall already drives the next segment;
    // the final walk ends on the fall that closes the last high phase.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
            state     <= ST_TLR;
`else
            // Parked in RESP with nothing pending: drains to IDLE on the
            // first clk after reset.
            state     <= ST_RESP;
`endif
            bit_idx   <= '0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        data_q   <= cmd_data;
                        len_q    <= cmd_len;
                        is_ir_q  <= cmd_is_ir;
                        bit_idx  <= '0;
                        rsp_data <= '0;
                        rsp_err  <= len_bad;
                        if (len_bad) begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            state     <= ST_PRE;
                        end
                    end
                end
`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
                ST_TLR: begin
                    if (fall_stb) begin
                        if (bit_idx == TLR_TCK) begin
                            bit_idx <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            tms <= TLR_TMS[bit_idx[2:0]];
                            tdi <= 1'b0;
                        end
                    end
                    if (rise_stb)
                        bit_idx <= bit_idx + 6'd1;
                end
`endif
                ST_PRE: begin
                    if (fall_stb) begin
                        tms <= pre_tms(is_ir_q, bit_idx[1:0]);
                        tdi <= 1'b0;
                    end
                    if (rise_stb) begin
                        if (bit_idx == pre_last) begin
                            bit_idx <= '0;
                            state   <= ST_SHIFT;
                        end else begin
                            bit_idx <= bit_idx + 6'd1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (fall_stb) begin
                        tdi <= data_q[bit_idx];
                        tms <= shift_last;
                    end
                    if (rise_stb) begin
                        rsp_data[bit_idx] <= tdo;
                        if (shift_last) begin
                            bit_idx <= '0;
                            state   <= ST_POST;
                        end else begin
                            bit_idx <= bit_idx + 6'd1;
                        end
                    end
                end
                ST_POST: begin
                    if (fall_stb) begin
                        tdi <= 1'b0;
                        if (bit_idx == POST_TCK) begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            tms <= (bit_idx == 6'd0);
                        end
                    end
                    if (rise_stb)
                        bit_idx <= bit_idx + 6'd1;
                end
                ST_RESP: begin
                    if (!rsp_valid || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per TCK half-period; legal range 1..255.
REQ-002 Parameter MAX_LEN, default 38, maximum scan length in bits; matches the debug-module jdo/sr width.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_is_ir  input  1  1 = IR scan, 0 = DR scan.
REQ-008 cmd_len  input  6  scan length in bits.
REQ-009 cmd_data  input  MAX_LEN  bits to shift in, LSB first.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-012 rsp_data  output  MAX_LEN  TDO bits captured, LSB first; bits at index >= len are 0.
REQ-013 rsp_err  output  1  illegal cmd_len; no TCK activity took place.
REQ-014 tck, tms, tdi  output  1 each  TAP drive pins.
REQ-015 tdo  input  1  TAP data out.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States are IDLE, TLR, PRE, SHIFT, POST and RESP; the FSM leaves IDLE only on a command handshake.
REQ-018 One TCK cycle is a low phase of CLK_DIV clks followed by a high phase of CLK_DIV clks; tck idles low.
REQ-019 tms and tdi change only on the clk that starts a low phase.
REQ-020 tdo is sampled on the clk where tck goes high.
REQ-021 PRE drives a TMS sequence from Run-Test/Idle: IR scan 1,1,0,0 (4 TCK); DR scan 1,0,0 (3 TCK).
REQ-022 SHIFT drives len TCK cycles: tdi = cmd_data[i] in bit order 0..len-1; tms = 0 except 1 on bit len-1.
REQ-023 POST drives tms 1 (Update) then 0 (Run-Test/Idle), 2 TCK; tdi = 0 outside SHIFT.
REQ-024 Total TCK count is len+6 for an IR scan and len+5 for a DR scan.
REQ-025 rsp_valid rises on the clk after the last TCK high phase ends and holds until rsp_ready.
REQ-026 rsp_data and rsp_err stay stable while rsp_valid is high.
REQ-027 cmd_ready = 1 only in IDLE.
REQ-028 A new command is accepted no earlier than the clk after the response handshake.
REQ-029 cmd_len == 0 or cmd_len > MAX_LEN: go directly to RESP with rsp_err = 1, rsp_data = 0, no tck edge.
REQ-030 cmd_len == 1: the single shifted bit carries tms = 1.
REQ-031 cmd_data is registered at acceptance; later changes on the cmd_data input have no effect.

Reset
REQ-032 Reset values: tck = 0, tms = 1, tdi = 0, cmd_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_data = 0, busy = 1, divider counter = 0.
REQ-033 Reset asserted mid-scan aborts the scan on the next clk with no response; the TAP state is then recovered per REQ-034/REQ-035.

Configuration
REQ-034 With JTAG_SCAN_MASTER_TAP_RESET_EN defined, after reset the FSM enters TLR and drives tms 1,1,1,1,1,0 (6 TCK), then enters IDLE, forcing the TAP to Run-Test/Idle.
REQ-035 With JTAG_SCAN_MASTER_TAP_RESET_EN not defined, the FSM enters IDLE on the first clk after reset deasserts, the TLR state is absent, and the TAP is taken to be in Run-Test/Idle.

Structure
REQ-036 Shared package jtag_scan_pkg holds the state enum, the PRE TMS sequence constants and a MAX_LEN_DEFAULT constant.
REQ-037 One sub-module, jtag_tck_gen, holds the divider and emits one-clk strobes fall_stb and rise_stb plus tck; the FSM advances only on those strobes.

Verification
REQ-038 DR scan, CLK_DIV = 2, len = 8, data 0xA5, with a TAP model whose DR is 8'h3C -> 13 TCK, tdi sequence 1,0,1,0,0,1,0,1, rsp_data = 0x3C, rsp_err = 0.
REQ-039 IR scan, len = 2, data 2'b10, with a TAP model returning IR capture 2'b01 -> 8 TCK, TMS stream 1,1,0,0,0,1,1,0, rsp_data = 2'b01.
REQ-040 len = 38, data 0x2A_AAAA_AAAA -> all 38 bits loop back through a TAP bypass-free model, rsp_data equal to the input data, 43 TCK.
REQ-041 len = 0 and len = 39 -> rsp_err = 1 on the clk after acceptance, no tck edge, rsp_data = 0.
REQ-042 rsp_ready held low for 20 clks -> rsp_valid and rsp_data stable, cmd_ready = 0, a second cmd_valid is not accepted.
REQ-043 Reset pulsed during bit 5 of a 20-bit scan -> outputs return to the REQ-032 values, TLR issues 6 TCK with the macro and none without it, and the TAP model ends in Run-Test/Idle with the macro defined.
